// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU host-write scheduler.
package ppu_pkg;

   // Table targeted by a host write, decoded from address[9:8].
   typedef enum logic [1:0] {
      ATTR    = 2'b00,
      SPRITE  = 2'b01,
      COLOR   = 2'b10,
      INVALID = 2'b11
   } tbl_sel_e;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      PENDING = 2'b01,
      DRAIN   = 2'b10
   } sched_state_e;

   // Table updates are allowed from line 480 through 523. Line 524 stays
   // closed so the line-0 sprite fetch never sees a half-written table.
   localparam logic [9:0] VBLANK_FIRST = 10'd480;
   localparam logic [9:0] VBLANK_LAST  = 10'd523;
   localparam logic [9:0] VTOTAL       = 10'd525;

   // Queued entry header; the DATA_W-wide data word is appended below it
   // by the scheduler because the data width is a module parameter.
   typedef struct packed {
      tbl_sel_e   sel;
      logic [7:0] addr;
   } ppu_entry_t;

   // One-hot table write enable: bit0 attribute, bit1 sprite, bit2 color.
   function automatic logic [2:0] sel_to_we(input tbl_sel_e sel);
      case (sel)
         ATTR:    return 3'b001;
         SPRITE:  return 3'b010;
         COLOR:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth. Occupancy, full and empty come
// straight from flops; read data is the storage word at the read pointer.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic             push_ok, pop_ok;

   // Pointer and occupancy update; pointers wrap naturally modulo DEPTH.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      push_ok  = push && !full_q;
      pop_ok   = pop && !empty_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CNT_W'(DEPTH));
      empty_d = (count_d == '0);
   end

   // Control flops, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage array.
   always_ff @(posedge clk) begin
      // NOTE: the array is deliberately not reset; pointers and count define validity.
      if (push_ok) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign full    = full_q;
   assign empty   = empty_q;
   assign count   = count_q;

endmodule

// File: rtl/ppu_write_scheduler.sv
// PPU host-write scheduler: queues host table writes and commits them to the
// attribute/sprite/color tables only inside the vertical-blank window.
// Build option: define PPU_VBLANK_GATE_EN to gate draining to lines 480..523;
// left undefined, the window is always open and writes drain immediately.
module ppu_write_scheduler
   import ppu_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int DATA_W     = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          chipselect,
   input  logic                          write,
   input  logic [15:0]                   address,
   input  logic [DATA_W-1:0]             writedata,
   output logic                          waitrequest,
   input  logic [10:0]                   hcount,
   input  logic [9:0]                    vcount,
   output logic [2:0]                    mem_we,
   output logic [7:0]                    mem_addr,
   output logic [DATA_W-1:0]             mem_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          flush_done
);

   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int ENTRY_W = $bits(ppu_entry_t) + DATA_W;

   sched_state_e      state_q, state_d;
   logic [2:0]        mem_we_q, mem_we_d;
   logic [7:0]        mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic              flush_done_q, flush_done_d;

   tbl_sel_e          wr_sel;
   ppu_entry_t        wr_hdr, rd_hdr;
   logic [DATA_W-1:0] rd_word;
   logic [ENTRY_W-1:0] fifo_rd_data;
   logic              fifo_full, fifo_empty;
   logic              push, pop, window_open;
   logic              unused_inputs;

   assign wr_sel      = tbl_sel_e'(address[9:8]);
   assign wr_hdr      = '{sel: wr_sel, addr: address[7:0]};
   // No bypass: a pop in the same cycle does not lift the stall.
   assign waitrequest = chipselect && write && fifo_full;
   // Invalid-table writes are accepted but never queued.
   assign push        = chipselect && write && !waitrequest && (wr_sel != INVALID);
   assign {rd_hdr, rd_word} = fifo_rd_data;
   assign unused_inputs = ^{hcount, vcount, address[15:10]};

`ifdef PPU_VBLANK_GATE_EN
   assign window_open = (vcount >= VBLANK_FIRST) && (vcount <= VBLANK_LAST);
`else
   assign window_open = 1'b1;
`endif

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .wr_data ({wr_hdr, writedata}),
      .pop     (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Scheduler FSM; the PENDING->DRAIN move pops in the same cycle to keep
   // accept-to-commit latency at two cycles.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) state_d = PENDING;
         end
         PENDING: begin
            if (fifo_empty) begin
               state_d = IDLE;
            end else if (window_open) begin
               pop     = 1'b1;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!window_open) begin
               state_d = fifo_empty ? IDLE : PENDING;
            end else if (!fifo_empty) begin
               pop = 1'b1;
               if (fifo_count == CNT_W'(1) && !push) state_d = IDLE;
            end else if (!push) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Table-port outputs: pulse the enable per popped entry, hold addr/data.
   always_comb begin
      mem_we_d     = 3'b000;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      flush_done_d = 1'b0;
      if (pop) begin
         mem_we_d     = sel_to_we(rd_hdr.sel);
         mem_addr_d   = rd_hdr.addr;
         mem_data_d   = rd_word;
         flush_done_d = (fifo_count == CNT_W'(1)) && !push;
      end
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         mem_we_q     <= 3'b000;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         flush_done_q <= flush_done_d;
      end
   end

   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_data   = mem_data_q;
   assign flush_done = flush_done_q;

endmodule

// File: tb/tb_ppu_write_scheduler.sv
// Directed bench for ppu_write_scheduler. A negedge monitor compares every
// table write pulse against a queue of expected commits built by the stimulus.
module tb_ppu_write_scheduler;
   import ppu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        chipselect, write;
   logic [15:0] address;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [2:0]  mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_data;
   logic [3:0]  fifo_count;
   logic        flush_done;

   typedef struct {
      logic [2:0]  we;
      logic [7:0]  addr;
      logic [31:0] data;
      logic        flush;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   ppu_write_scheduler #(.FIFO_DEPTH(8), .DATA_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .chipselect (chipselect),
      .write      (write),
      .address    (address),
      .writedata  (writedata),
      .waitrequest(waitrequest),
      .hcount     (hcount),
      .vcount     (vcount),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .fifo_count (fifo_count),
      .flush_done (flush_done)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] exp_we(input logic [1:0] s);
      case (s)
         2'b00:   return 3'b001;
         2'b01:   return 3'b010;
         2'b10:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // Drive one host write and hold it until accepted (bounded).
   task automatic host_write(input logic [15:0] a, input logic [31:0] d, input logic last);
      logic stalled;
      int   n;
      stalled = 1'b1;
      n = 0;
      @(negedge clk);
      chipselect = 1'b1;
      write      = 1'b1;
      address    = a;
      writedata  = d;
      while (stalled && n < 2000) begin
         #1 stalled = waitrequest;
         @(posedge clk);
         if (stalled) @(negedge clk);
         n++;
      end
      if (stalled) check("accept_timeout", {63'd0, stalled}, 64'd0);
      else if (a[9:8] != 2'b11)
         exp_q.push_back('{we: exp_we(a[9:8]), addr: a[7:0], data: d, flush: last});
   endtask

   task automatic idle();
      @(negedge clk);
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   task automatic wait_neg(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Scoreboard monitor for table write pulses.
   always @(negedge clk) begin
      if (!reset) begin
         if (mem_we != 3'b000) begin
            if (exp_q.size() == 0) begin
               check("spurious_we", {61'd0, mem_we}, 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("commit_we",    {61'd0, mem_we},     {61'd0, e.we});
               check("commit_addr",  {56'd0, mem_addr},   {56'd0, e.addr});
               check("commit_data",  {32'd0, mem_data},   {32'd0, e.data});
               check("commit_flush", {63'd0, flush_done}, {63'd0, e.flush});
            end
         end else if (flush_done) begin
            check("flush_stray", {63'd0, flush_done}, 64'd0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      chipselect = 1'b1;
      write      = 1'b1;
      address    = 16'h0000;
      writedata  = 32'h0;
      hcount     = 11'd0;
`ifdef PPU_VBLANK_GATE_EN
      vcount     = 10'd480;
`else
      vcount     = 10'd10;
`endif
      #25;
      // Reset state, with a write strobe present during reset.
      check("rst_waitrequest", {63'd0, waitrequest}, 64'd0);
      check("rst_mem_we",      {61'd0, mem_we},      64'd0);
      check("rst_mem_addr",    {56'd0, mem_addr},    64'd0);
      check("rst_mem_data",    {32'd0, mem_data},    64'd0);
      check("rst_fifo_count",  {60'd0, fifo_count},  64'd0);
      check("rst_flush_done",  {63'd0, flush_done},  64'd0);
      @(negedge clk);
      chipselect = 1'b0;
      write      = 1'b0;
      reset      = 1'b0;
      wait_neg(2);

      // Single write with an open window: pulse two edges after accept.
      host_write(16'h0105, 32'hA5A5_0001, 1'b1);
      idle();
      check("lat_edge0", {61'd0, mem_we}, 64'd0);
      @(negedge clk);
      check("lat_edge1", {61'd0, mem_we}, 64'd0);
      @(negedge clk);
      check("lat_edge2", {61'd0, mem_we}, 64'd2);
      wait_neg(3);
      check("hold_we",   {61'd0, mem_we},   64'd0);
      check("hold_addr", {56'd0, mem_addr}, 64'h05);
      check("hold_data", {32'd0, mem_data}, 64'hA5A5_0001);

      // Three tables back to back; flush on the third only.
      host_write(16'h0005, 32'h0000_AAAA, 1'b0);
      host_write(16'h0103, 32'h0000_BBBB, 1'b0);
      host_write(16'h0207, 32'h0000_CCCC, 1'b1);
      idle();
      wait_neg(6);

      // Invalid table: accepted without stall, never queued.
      @(negedge clk);
      chipselect = 1'b1;
      write      = 1'b1;
      address    = 16'h0300;
      writedata  = 32'hDEAD_0300;
      #1 check("inv_no_stall", {63'd0, waitrequest}, 64'd0);
      @(posedge clk);
      #1 check("inv_count", {60'd0, fifo_count}, 64'd0);
      idle();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("inv_no_we", {61'd0, mem_we}, 64'd0);
      end

      // Invalid write between two valid ones keeps order and is dropped.
      host_write(16'h0011, 32'h1111_0011, 1'b0);
      host_write(16'h03AA, 32'hBAD0_03AA, 1'b0);
      host_write(16'h0222, 32'h2222_0222, 1'b1);
      idle();
      wait_neg(6);

      // Ten back-to-back writes: pointer wrap, steady count on push+pop.
      for (int i = 0; i < 10; i++) begin
         host_write({6'd0, 2'(i % 3), 8'(i * 17)}, 32'h1000_0000 + 32'(i), (i == 9));
         if (i == 5) #1 check("pushpop_count", {60'd0, fifo_count}, 64'd2);
      end
      idle();
      wait_neg(6);
      check("wrap_drained", 64'(exp_q.size()), 64'd0);

`ifdef PPU_VBLANK_GATE_EN
      // Writes outside the window wait for line 480.
      vcount = 10'd100;
      host_write(16'h0005, 32'h3000_0005, 1'b0);
      host_write(16'h0103, 32'h3000_0103, 1'b0);
      host_write(16'h0207, 32'h3000_0207, 1'b1);
      idle();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("gate_closed_we", {61'd0, mem_we}, 64'd0);
      end
      vcount = 10'd480;
      wait_neg(6);
      check("gate_drained", 64'(exp_q.size()), 64'd0);

      // Nine writes into an 8-deep queue: the ninth stalls until a pop.
      vcount = 10'd100;
      for (int i = 0; i < 8; i++)
         host_write(16'h0100 + 16'(i), 32'h3100_0000 + 32'(i), 1'b0);
      @(negedge clk);
      chipselect = 1'b1;
      write      = 1'b1;
      address    = 16'h0108;
      writedata  = 32'h3100_0008;
      #1 check("stall_9th", {63'd0, waitrequest}, 64'd1);
      check("full_count", {60'd0, fifo_count}, 64'd8);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1 check("stall_hold", {63'd0, waitrequest}, 64'd1);
      end
      vcount = 10'd480;
      #1 check("stall_no_bypass", {63'd0, waitrequest}, 64'd1);
      @(negedge clk);
      #1 check("stall_release", {63'd0, waitrequest}, 64'd0);
      @(posedge clk);
      exp_q.push_back('{we: 3'b010, addr: 8'h08, data: 32'h3100_0008, flush: 1'b1});
      idle();
      wait_neg(14);
      check("full_drained", 64'(exp_q.size()), 64'd0);

      // Window closes after two pops; the rest waits for the next frame.
      vcount = 10'd100;
      for (int i = 0; i < 5; i++)
         host_write(16'h0040 + 16'(i), 32'h3200_0000 + 32'(i), (i == 4));
      idle();
      wait_neg(2);
      vcount = 10'd522;
      @(negedge clk);
      vcount = 10'd523;
      @(negedge clk);
      vcount = 10'd524;
      @(negedge clk);
      check("close_count", {60'd0, fifo_count}, 64'd3);
      check("close_state", 64'(dut.state_q), 64'(PENDING));
      wait_neg(3);
      check("close_left", 64'(exp_q.size()), 64'd3);
      vcount = 10'd480;
      wait_neg(6);
      check("close_drained", 64'(exp_q.size()), 64'd0);
`endif

      // Asynchronous reset in the middle of a drain.
      host_write(16'h0010, 32'h4000_0010, 1'b0);
      host_write(16'h0111, 32'h4000_0111, 1'b0);
      host_write(16'h0212, 32'h4000_0212, 1'b0);
      #3;
      reset      = 1'b1;
      chipselect = 1'b0;
      write      = 1'b0;
      exp_q.delete();
      #1;
      check("arst_mem_we",     {61'd0, mem_we},     64'd0);
      check("arst_mem_addr",   {56'd0, mem_addr},   64'd0);
      check("arst_mem_data",   {32'd0, mem_data},   64'd0);
      check("arst_fifo_count", {60'd0, fifo_count}, 64'd0);
      check("arst_flush_done", {63'd0, flush_done}, 64'd0);
      wait_neg(2);
      reset = 1'b0;
      wait_neg(10);
      check("post_rst_count", {60'd0, fifo_count}, 64'd0);
      host_write(16'h0207, 32'hCAFE_0007, 1'b1);
      idle();
      wait_neg(5);
      check("final_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
